// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode encodings and counts shared by the LED pattern engine
package led_pattern_pkg;
  localparam logic [1:0] MODE_BOUNCE = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_FILL   = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;
  localparam int NUM_MODES  = 4;
  localparam int NUM_SPEEDS = 4;
endpackage

// File: rtl/step_timer.sv
// step_timer: speed-selected step period counter with pause hold and clear
module step_timer #(
  parameter int BASE_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic       hold,
  input  logic       clear,
  output logic       step_en
);
  localparam int CW  = $clog2(4 * BASE_CYCLES);
  localparam int CW1 = CW + 1;
  logic [CW-1:0] cnt;
  logic [CW:0] last;
  always_comb begin
    last = speed == 2'd0 ? CW1'(BASE_CYCLES - 1)
         : speed == 2'd1 ? CW1'(2 * BASE_CYCLES - 1)
         : speed == 2'd2 ? CW1'(3 * BASE_CYCLES - 1)
         : CW1'(4 * BASE_CYCLES - 1);
    step_en = !hold && !clear && {1'b0, cnt} == last;
  end
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (!hold) cnt <= step_en ? '0 : cnt + CW'(1);
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: N-wide LED pattern engine with four modes, four speeds and pause
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int CLK_HZ      = 125_000_000,
  parameter int N_LEDS      = 4,
  parameter int BASE_CYCLES = CLK_HZ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_pulse,
  input  logic              speed_pulse,
  input  logic              pause_pulse,
  output logic [N_LEDS-1:0] leds,
  output logic [1:0]        mode,
  output logic [1:0]        speed,
  output logic              paused,
  output logic              step_tick
);
  localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);
  logic step_en, dir, bnc_dir;
  logic [1:0] mode_nx;
  logic [N_LEDS-1:0] nxt_leds;
  step_timer #(.BASE_CYCLES(BASE_CYCLES)) u_step_timer (
    .clk,
    .rst,
    .speed,
    .hold(paused),
    .clear(mode_pulse | speed_pulse),
    .step_en
  );
  always_comb begin
    mode_nx = mode + 2'd1;
    bnc_dir = dir ? !leds[N_LEDS-1] : leds[0];
    nxt_leds = mode == MODE_BOUNCE ? (bnc_dir ? leds << 1 : leds >> 1)
             : mode == MODE_ROTATE ? {leds[N_LEDS-2:0], leds[N_LEDS-1]}
             : mode == MODE_FILL   ? (&leds ? ONE : {leds[N_LEDS-2:0], 1'b1})
             : ~leds;
  end
  always_ff @(posedge clk)
    if (rst) begin
      leds      <= ONE;
      dir       <= 1'b1;
      mode      <= MODE_BOUNCE;
      speed     <= 2'd0;
      paused    <= 1'b0;
      step_tick <= 1'b0;
    end else begin
      mode      <= mode_pulse ? mode_nx : mode;
      speed     <= speed + 2'(speed_pulse);
      paused    <= paused ^ pause_pulse;
      step_tick <= step_en;
      if (mode_pulse) begin
        leds <= mode_nx == MODE_BLINK ? '1 : ONE;
        dir  <= 1'b1;
      end else if (step_en) begin
        leds <= nxt_leds;
        dir  <= mode == MODE_BOUNCE ? bnc_dir : dir;
      end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: vector table plus randomized run against a step-index pattern model
module tb_led_pattern_gen;
  localparam int N = 4;
  localparam int B = 10;
  logic clk = 1'b0;
  logic rst, mode_pulse, speed_pulse, pause_pulse;
  logic [N-1:0] leds;
  logic [1:0] mode, speed;
  logic paused, step_tick;
  int n_cmp = 0;
  int n_bad = 0;
  int m_mode, m_speed, m_paused, m_cnt, m_pos, m_tick;
  typedef struct {
    logic r, m, s, p;
    int n;
    logic [N-1:0] leds;
    int mode, speed, paused, tick;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  led_pattern_gen #(.CLK_HZ(100), .N_LEDS(N), .BASE_CYCLES(B)) dut (
    .clk(clk),
    .rst(rst),
    .mode_pulse(mode_pulse),
    .speed_pulse(speed_pulse),
    .pause_pulse(pause_pulse),
    .leds(leds),
    .mode(mode),
    .speed(speed),
    .paused(paused),
    .step_tick(step_tick)
  );
  function automatic logic [N-1:0] pat(int md, int k);
    int i;
    logic [N-1:0] one = N'(1);
    case (md)
      0: begin
        i = k % (2 * N - 2);
        i = i < N ? i : 2 * N - 2 - i;
        return one << i;
      end
      1: return one << (k % N);
      2: return N'((1 << (k % N + 1)) - 1);
      default: return k % 2 == 0 ? '1 : '0;
    endcase
  endfunction
  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic m, input logic s, input logic p);
    rst = r;
    mode_pulse = m;
    speed_pulse = s;
    pause_pulse = p;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_speed = 0; m_paused = 0; m_cnt = 0; m_pos = 0; m_tick = 0;
    end else begin
      m_tick = (m_paused == 0 && !m && !s && m_cnt == (m_speed + 1) * B - 1) ? 1 : 0;
      if (m || s) m_cnt = 0;
      else if (m_paused == 0) m_cnt = m_tick ? 0 : m_cnt + 1;
      if (m) m_pos = 0;
      else if (m_tick == 1) m_pos++;
      m_mode = (m_mode + int'(m)) % 4;
      m_speed = (m_speed + int'(s)) % 4;
      m_paused = m_paused ^ int'(p);
    end
    #1;
    chk("model leds", int'(leds), int'(pat(m_mode, m_pos)));
    chk("model mode", int'(mode), m_mode);
    chk("model speed", int'(speed), m_speed);
    chk("model paused", int'(paused), m_paused);
    chk("model step_tick", int'(step_tick), m_tick);
    rst = 1'b0;
    mode_pulse = 1'b0;
    speed_pulse = 1'b0;
    pause_pulse = 1'b0;
  endtask
  initial begin
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 10,  4'b0010, 0, 0, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5,   4'b0010, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1,   4'b0010, 0, 0, 1, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 100, 4'b0010, 0, 0, 1, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1,   4'b0010, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3,   4'b0010, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1,   4'b0100, 0, 0, 0, 1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1,   4'b0001, 1, 0, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 10,  4'b0010, 1, 0, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1,   4'b0010, 1, 1, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1,   4'b0010, 1, 2, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 29,  4'b0010, 1, 2, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1,   4'b0100, 1, 2, 0, 1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1,   4'b0001, 2, 2, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1,   4'b0001, 2, 3, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1,   4'b0001, 2, 0, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 10,  4'b0011, 2, 0, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20,  4'b1111, 2, 0, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 10,  4'b0001, 2, 0, 0, 1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1,   4'b1111, 3, 0, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 10,  4'b0000, 3, 0, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 10,  4'b1111, 3, 0, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 9,   4'b1111, 3, 0, 0, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1,   4'b0001, 0, 1, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 19,  4'b0001, 0, 1, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1,   4'b0010, 0, 1, 0, 1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1,   4'b0001, 1, 1, 1, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 50,  4'b0001, 1, 1, 1, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1,   4'b0001, 2, 1, 1, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1,   4'b0001, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 10,  4'b0010, 0, 0, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 9,   4'b0010, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1,   4'b0001, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 10,  4'b0010, 0, 0, 0, 1});
    rst = 1'b1;
    mode_pulse = 1'b0;
    speed_pulse = 1'b0;
    pause_pulse = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset leds", int'(leds), 1);
    chk("reset mode", int'(mode), 0);
    chk("reset speed", int'(speed), 0);
    chk("reset paused", int'(paused), 0);
    chk("reset step_tick", int'(step_tick), 0);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].m, tbl[i].s, tbl[i].p);
      repeat (tbl[i].n - 1) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d leds", i), int'(leds), int'(tbl[i].leds));
      chk($sformatf("vec%0d mode", i), int'(mode), tbl[i].mode);
      chk($sformatf("vec%0d speed", i), int'(speed), tbl[i].speed);
      chk($sformatf("vec%0d paused", i), int'(paused), tbl[i].paused);
      chk($sformatf("vec%0d step_tick", i), int'(step_tick), tbl[i].tick);
    end
    repeat (5000)
      cyc($urandom_range(399) == 0, $urandom_range(149) == 0,
          $urandom_range(149) == 0, $urandom_range(99) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
